// File: rtl/mux_scanner.sv
// Scans a downstream 4->1 mux: steps sel through channels 0..3, holds each for
// HOLD_CYCLES cycles, samples z at the end of each hold, and publishes the word.
module mux_scanner #(
   parameter int unsigned HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       cont,
   input  logic       z,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] data_out
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

   state_t     state_q;
   logic [1:0] chan_q;
   logic [7:0] hold_q;
   logic [3:0] word_q;
   logic [3:0] word_d;
   logic       busy_q;
   logic       done_q;
   logic [3:0] data_q;

   // Working word with the current channel's sample merged in.
   always_comb begin
      word_d         = word_q;
      word_d[chan_q] = z;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         chan_q  <= 2'd0;
         hold_q  <= 8'd0;
         word_q  <= 4'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= 4'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SCAN;
                  busy_q  <= 1'b1;
                  chan_q  <= 2'd0;
                  hold_q  <= 8'd0;
                  word_q  <= 4'd0;
               end
            end
            SCAN: begin
               if (hold_q != HOLD_LAST) begin
                  hold_q <= hold_q + 8'd1;
               end else begin
                  hold_q <= 8'd0;
                  word_q <= word_d;
                  if (chan_q != 2'd3) begin
                     chan_q <= chan_q + 2'd1;
                  end else begin
                     // Scan complete: publish, pulse done, then restart or idle.
                     chan_q <= 2'd0;
                     word_q <= 4'd0;
                     data_q <= word_d;
                     done_q <= 1'b1;
                     if (!cont) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sel      = chan_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign data_out = data_q;

endmodule

// File: doc/mux_scanner.md
MUX_SCANNER -- requirements
Module: mux_scanner

Interface
REQ-001 SHALL have parameter: HOLD_CYCLES, default 1, cycles each select value is held before z is sampled; legal range 1..255.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start  input  1  request one scan of channels 0..3; sampled only in IDLE.
REQ-005 SHALL have port: cont  input  1  continuous mode; sampled at the end of each scan.
REQ-006 SHALL have port: z  input  1  output of the downstream-driven 4->1 mux being scanned.
REQ-007 SHALL have port: sel  output  2  select value driven to the mux.
REQ-008 SHALL have port: busy  output  1  high while a scan is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking a completed scan.
REQ-010 SHALL have port: data_out  output  4  last completed scan; bit i = z sampled while sel = i.

Function
REQ-011 SHALL implement FSM states IDLE and SCAN, a channel index (2 bits) and a hold counter (8 bits).
REQ-012 SHALL register all outputs; no combinational path from any input to any output.
REQ-013 In IDLE: sel = 0, busy = 0; data_out holds its last value.
REQ-014 start = 1 at edge E in IDLE: SHALL enter SCAN; busy = 1 and sel = 0 from cycle after E.
REQ-015 Each channel i SHALL be presented on sel for exactly HOLD_CYCLES cycles, then advance to i+1.
REQ-016 z SHALL be captured into internal word bit i at the edge that ends the last hold cycle of channel i.
REQ-017 Scan accepted at edge E SHALL capture channel 3 at edge E + 4*HOLD_CYCLES.
REQ-018 At that edge: data_out <= full captured word; done = 1 for exactly the following cycle.
REQ-019 At that edge with cont = 0: return to IDLE; busy = 0 and sel = 0 in the done cycle.
REQ-020 At that edge with cont = 1: start a new scan immediately; sel = 0, busy stays 1, no idle gap; done still pulses.
REQ-021 start SHALL be ignored while in SCAN; it SHALL neither restart nor extend the current scan.
REQ-022 start = 1 during the done cycle (state IDLE) SHALL be accepted per REQ-014.
REQ-023 data_out SHALL change only at scan completion; partial scans are never visible.
REQ-024 Channel index SHALL wrap 3 -> 0 only through scan completion, never mid-scan.
REQ-025 Changes to cont mid-scan SHALL have no effect; only its value at the completion edge counts.

Reset
REQ-026 rst = 1 SHALL immediately force: state IDLE, sel = 0, busy = 0, done = 0, data_out = 4'b0000, counters = 0.
REQ-027 rst asserted mid-scan SHALL discard the partial word; after release, no done occurs until a new start is accepted.
REQ-028 First start accepted SHALL be at the first rising edge with rst = 0.

Verification
REQ-029 HOLD_CYCLES=1, mux d0..d3 = 1,0,1,1, start pulse at edge 0 -> sel 0,1,2,3 in cycles 1..4; done = 1 in cycle 5; data_out = 4'b1101; busy = 0 in cycle 5.
REQ-030 HOLD_CYCLES=3, d0..d3 = 0,1,1,0, start at edge 0 -> each sel value held 3 cycles; done in cycle 13 only; data_out = 4'b0110.
REQ-031 HOLD_CYCLES=1, start held high for 10 cycles, cont = 0 -> done in cycles 5 and 10; one idle/done cycle between scans; no restart during a scan.
REQ-032 HOLD_CYCLES=1, cont = 1, d inputs changed between scans (1,1,1,1 then 0,0,0,0) -> done in cycles 5 and 9; busy continuously 1; data_out 4'b1111 then 4'b0000.
REQ-033 HOLD_CYCLES=2, rst pulsed in cycle 5 of a scan with data_out previously 4'b1010 -> data_out = 0, sel = 0, busy = 0 immediately; no done until a new start; next scan completes normally.
